// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one functional-unit result per cycle (scalu, mcalu, lsq)
// by round-robin and registers it onto the single writeback bus toward ROB/regfile.
// Losing sources are held off with a per-source stall; rob_flush discards everything.
module wb_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ROBID_W = 8,
   parameter int RD_W    = 6
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               scalu_valid,
   input  logic               scalu_error,
   input  logic [4:0]         scalu_ecause,
   input  logic [ROBID_W-1:0] scalu_robid,
   input  logic [RD_W-1:0]    scalu_rd,
   input  logic [DATA_W-1:0]  scalu_result,
   output logic               wb_scalu_stall,

   input  logic               mcalu_valid,
   input  logic               mcalu_error,
   input  logic [4:0]         mcalu_ecause,
   input  logic [ROBID_W-1:0] mcalu_robid,
   input  logic [RD_W-1:0]    mcalu_rd,
   input  logic [DATA_W-1:0]  mcalu_result,
   output logic               wb_mcalu_stall,

   input  logic               lsq_valid,
   input  logic               lsq_error,
   input  logic [4:0]         lsq_ecause,
   input  logic [ROBID_W-1:0] lsq_robid,
   input  logic [RD_W-1:0]    lsq_rd,
   input  logic [DATA_W-1:0]  lsq_result,
   output logic               wb_lsq_stall,

   input  logic               rob_flush,

   output logic               wb_valid,
   output logic               wb_error,
   output logic [4:0]         wb_ecause,
   output logic [ROBID_W-1:0] wb_robid,
   output logic [RD_W-1:0]    wb_rd,
   output logic [DATA_W-1:0]  wb_result
);

   // Source indices; the pointer only ever holds one of these three values.
   localparam logic [1:0] SRC_SCALU = 2'd0;
   localparam logic [1:0] SRC_MCALU = 2'd1;
   localparam logic [1:0] SRC_LSQ   = 2'd2;

   // Next source in round-robin order (wraps lsq -> scalu).
   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == SRC_LSQ) ? SRC_SCALU : s + 2'd1;
   endfunction

   logic [2:0]                 src_valid;
   logic [2:0]                 src_error;
   logic [2:0][4:0]            src_ecause;
   logic [2:0][ROBID_W-1:0]    src_robid;
   logic [2:0][RD_W-1:0]       src_rd;
   logic [2:0][DATA_W-1:0]     src_result;

   logic [1:0]                 ptr;
   logic [2:0]                 grant;
   logic                       grant_any;
   logic [1:0]                 grant_idx;
   logic [1:0]                 cand;

   assign src_valid  = {lsq_valid,  mcalu_valid,  scalu_valid};
   assign src_error  = {lsq_error,  mcalu_error,  scalu_error};
   assign src_ecause = {lsq_ecause, mcalu_ecause, scalu_ecause};
   assign src_robid  = {lsq_robid,  mcalu_robid,  scalu_robid};
   assign src_rd     = {lsq_rd,     mcalu_rd,     scalu_rd};
   assign src_result = {lsq_result, mcalu_result, scalu_result};

   // Round-robin grant: first valid source scanning ptr, ptr+1, ptr+2 (mod 3); nothing on flush.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = SRC_SCALU;
      cand      = ptr;
      if (!rob_flush) begin
         for (int unsigned k = 0; k < 3; k++) begin
            if (!grant_any && src_valid[cand]) begin
               grant_any   = 1'b1;
               grant_idx   = cand;
               grant[cand] = 1'b1;
            end
            cand = next_src(cand);
         end
      end
   end

   // A pending result that did not win waits; on flush every source drops instead.
   assign wb_scalu_stall = scalu_valid & ~grant[SRC_SCALU] & ~rob_flush;
   assign wb_mcalu_stall = mcalu_valid & ~grant[SRC_MCALU] & ~rob_flush;
   assign wb_lsq_stall   = lsq_valid   & ~grant[SRC_LSQ]   & ~rob_flush;

   // Register the granted result onto the writeback bus and advance the pointer past the winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid  <= 1'b0;
         wb_error  <= 1'b0;
         wb_ecause <= '0;
         wb_robid  <= '0;
         wb_rd     <= '0;
         wb_result <= '0;
         ptr       <= SRC_SCALU;
      end else if (grant_any) begin
         wb_valid  <= 1'b1;
         wb_error  <= src_error[grant_idx];
         wb_ecause <= src_ecause[grant_idx];
         wb_robid  <= src_robid[grant_idx];
         wb_rd     <= src_rd[grant_idx];
         wb_result <= src_result[grant_idx];
         ptr       <= next_src(grant_idx);
      end else begin
         wb_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then a long
// randomized run, all compared every cycle against a round-robin reference model.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [2:0]  v  = '0;
   logic [2:0]  er = '0;
   logic [4:0]  ec  [3];
   logic [7:0]  rid [3];
   logic [5:0]  rdv [3];
   logic [31:0] res [3];

   logic        wb_scalu_stall, wb_mcalu_stall, wb_lsq_stall;
   logic        wb_valid, wb_error;
   logic [4:0]  wb_ecause;
   logic [7:0]  wb_robid;
   logic [5:0]  wb_rd;
   logic [31:0] wb_result;

   always #5 clk = ~clk;

   wb_arbiter #(.DATA_W(32), .ROBID_W(8), .RD_W(6)) dut (
      .clk(clk), .rst(rst),
      .scalu_valid(v[0]), .scalu_error(er[0]), .scalu_ecause(ec[0]),
      .scalu_robid(rid[0]), .scalu_rd(rdv[0]), .scalu_result(res[0]),
      .wb_scalu_stall(wb_scalu_stall),
      .mcalu_valid(v[1]), .mcalu_error(er[1]), .mcalu_ecause(ec[1]),
      .mcalu_robid(rid[1]), .mcalu_rd(rdv[1]), .mcalu_result(res[1]),
      .wb_mcalu_stall(wb_mcalu_stall),
      .lsq_valid(v[2]), .lsq_error(er[2]), .lsq_ecause(ec[2]),
      .lsq_robid(rid[2]), .lsq_rd(rdv[2]), .lsq_result(res[2]),
      .wb_lsq_stall(wb_lsq_stall),
      .rob_flush(flush),
      .wb_valid(wb_valid), .wb_error(wb_error), .wb_ecause(wb_ecause),
      .wb_robid(wb_robid), .wb_rd(wb_rd), .wb_result(wb_result)
   );

   // Reference model state
   int          mptr = 0;
   int          mg;
   logic        e_valid = 1'b0, e_error = 1'b0;
   logic [4:0]  e_ec  = '0;
   logic [7:0]  e_rid = '0;
   logic [5:0]  e_rd  = '0;
   logic [31:0] e_res = '0;

   // Values sampled just before the edge, for literal checks
   logic        s_sc, s_mc, s_ls, s_pre_valid;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: check combinational stalls against the model, clock, update model, check bus.
   task automatic tick();
      int g;
      int idx;
      #1;
      g = -1;
      if (!flush) begin
         for (int k = 0; k < 3; k++) begin
            idx = (mptr + k) % 3;
            if (g < 0 && v[idx]) g = idx;
         end
      end
      s_sc = wb_scalu_stall;
      s_mc = wb_mcalu_stall;
      s_ls = wb_lsq_stall;
      s_pre_valid = wb_valid;
      chk("stall_scalu", s_sc, v[0] && g != 0 && !flush);
      chk("stall_mcalu", s_mc, v[1] && g != 1 && !flush);
      chk("stall_lsq",   s_ls, v[2] && g != 2 && !flush);
      @(posedge clk);
      if (rst) begin
         e_valid = 1'b0; e_error = 1'b0; e_ec = '0; e_rid = '0; e_rd = '0; e_res = '0;
         mptr = 0;
      end else if (g >= 0) begin
         e_valid = 1'b1; e_error = er[g]; e_ec = ec[g]; e_rid = rid[g]; e_rd = rdv[g]; e_res = res[g];
         mptr = (g + 1) % 3;
      end else begin
         e_valid = 1'b0;
      end
      mg = rst ? -1 : g;
      #1;
      chk("wb_valid",  wb_valid,  e_valid);
      chk("wb_error",  wb_error,  e_error);
      chk("wb_ecause", wb_ecause, e_ec);
      chk("wb_robid",  wb_robid,  e_rid);
      chk("wb_rd",     wb_rd,     e_rd);
      chk("wb_result", wb_result, e_res);
   endtask

   int unsigned exp_order [6] = '{10, 20, 30, 11, 21, 31};

   initial begin
      for (int i = 0; i < 3; i++) begin
         ec[i] = '0; rid[i] = '0; rdv[i] = '0; res[i] = '0;
      end

      // 1: reset, then idle
      tick(); tick();
      chk("t1_rst_valid",  wb_valid, 0);
      chk("t1_rst_error",  wb_error, 0);
      chk("t1_rst_ecause", wb_ecause, 0);
      chk("t1_rst_robid",  wb_robid, 0);
      chk("t1_rst_rd",     wb_rd, 0);
      chk("t1_rst_result", wb_result, 0);
      rst = 1'b0;
      tick(); tick();
      chk("t1_idle_valid", wb_valid, 0);

      // 2: scalu alone, back to back
      v = 3'b001;
      for (int i = 1; i <= 4; i++) begin
         rid[0] = 8'(i); rdv[0] = 6'(i + 3); res[0] = 32'(i * 100);
         tick();
         chk("t2_robid", wb_robid, i);
         chk("t2_valid", wb_valid, 1);
         chk("t2_stall", s_sc, 0);
      end
      v = '0;

      // 3: all three continuously valid from ptr=0
      rst = 1'b1; tick(); rst = 1'b0;
      rid[0] = 10; rid[1] = 20; rid[2] = 30;
      v = 3'b111;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) begin
            chk("t3_first_mc_stall",  s_mc, 1);
            chk("t3_first_lsq_stall", s_ls, 1);
         end
         chk("t3_order", wb_robid, exp_order[i]);
         if (mg >= 0) rid[mg] = rid[mg] + 8'd1;
      end
      v = '0;

      // 4: bring ptr to 2, then scalu+mcalu -> scalu wins by wrap, then mcalu
      v = 3'b010; rid[1] = 40;
      tick();
      chk("t4_setup", wb_robid, 40);
      v = 3'b011; rid[0] = 50; rid[1] = 41;
      tick();
      chk("t4_wrap_robid", wb_robid, 50);
      chk("t4_mc_waits",   s_mc, 1);
      v[0] = 1'b0;
      tick();
      chk("t4_mc_next", wb_robid, 41);
      v = '0;

      // 5: flush while mcalu waits (ptr=2 -> scalu wins first, ptr becomes 1)
      v = 3'b011; rid[0] = 60; rid[1] = 70;
      tick();
      chk("t5_first", wb_robid, 60);
      chk("t5_mc_waits", s_mc, 1);
      rid[0] = 61; flush = 1'b1;
      tick();
      chk("t5_flush_sc_stall", s_sc, 0);
      chk("t5_flush_mc_stall", s_mc, 0);
      chk("t5_pre_valid",      s_pre_valid, 1);
      chk("t5_flush_valid",    wb_valid, 0);
      flush = 1'b0; rid[0] = 62; rid[1] = 71;
      tick();
      chk("t5_ptr_held", wb_robid, 71);
      v = '0;

      // 6: error passthrough from lsq
      v = 3'b100; er[2] = 1'b1; ec[2] = 5'd4; res[2] = 32'hDEADBEEF; rid[2] = 99;
      tick();
      chk("t6_error",  wb_error, 1);
      chk("t6_ecause", wb_ecause, 4);
      chk("t6_result", wb_result, 32'hDEADBEEF);
      v = '0; er = '0;

      // Randomized run: sources hold while stalled, refill after grant, drop on flush/reset
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!v[i] && $urandom_range(9) < 7) begin
               v[i]   = 1'b1;
               er[i]  = ($urandom_range(7) == 0);
               ec[i]  = 5'($urandom);
               rid[i] = 8'($urandom);
               rdv[i] = 6'($urandom);
               res[i] = $urandom;
            end
         end
         flush = ($urandom_range(15) == 0);
         rst   = ($urandom_range(63) == 0);
         tick();
         if (rst || flush) v = '0;
         else if (mg >= 0) v[mg] = 1'b0;
         rst = 1'b0; flush = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
